// File: rtl/decimation_pkg.sv
// decimation_pkg: shared FSM states, minimum oversampling ratio and filter mode encodings.
package decimation_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_INTEGRATE, ST_CAPTURE} state_e;
  localparam int MIN_OSR = 2;
  localparam logic MODE_INCREMENTAL = 1'b0;
  localparam logic MODE_REGULAR = 1'b1;
endpackage

// File: rtl/sample_counter.sv
// sample_counter: counts enabled filter samples and flags the last one of a conversion.
module sample_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  // Holding at zero outside INTEGRATE gives the reset required on every conversion entry.
  assign cnt_d = run_i ? cnt_q + W'(1) : '0;
  assign tc_o = cnt_q == term_i - W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/decimation_sequencer.sv
// decimation_sequencer: sequences clear/integrate/capture of a decimation filter and hands results off.
module decimation_sequencer
  import decimation_pkg::*;
#(
  parameter int OUTPUT_BITS = 16,
  parameter int OSR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   mode,
  input  logic [OSR_BITS-1:0]    osr,
  output logic                   flt_clr,
  output logic                   flt_en,
  input  logic [OUTPUT_BITS-1:0] flt_data,
  output logic [OUTPUT_BITS-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   overrun
);
  state_e state_q, state_d;
  logic [OSR_BITS-1:0] osr_q, osr_d;
  logic mode_q, mode_d;
  logic [OUTPUT_BITS-1:0] res_data_q, res_data_d;
  logic res_valid_q, res_valid_d;
  logic overrun_q, overrun_d;
  logic tc;
  sample_counter #(.W(OSR_BITS)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .run_i (state_q == ST_INTEGRATE),
    .term_i(osr_q),
    .tc_o  (tc)
  );
  always_comb begin
    state_d = state_q;
    osr_d = osr_q;
    mode_d = mode_q;
    res_data_d = res_data_q;
    res_valid_d = res_valid_q && !res_ready;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: if (start || continuous) begin
        state_d = ST_CLEAR;
        osr_d = osr < OSR_BITS'(MIN_OSR) ? OSR_BITS'(MIN_OSR) : osr;
        mode_d = mode;
        overrun_d = overrun_q && !start;
      end
      ST_CLEAR: state_d = ST_INTEGRATE;
      ST_INTEGRATE: state_d = tc ? ST_CAPTURE : ST_INTEGRATE;
      ST_CAPTURE: begin
        state_d = !continuous ? ST_IDLE : mode_q == MODE_REGULAR ? ST_INTEGRATE : ST_CLEAR;
        // A result still waiting for the consumer wins; the new one is dropped and flagged.
        if (!res_valid_q || res_ready) begin
          res_data_d = flt_data;
          res_valid_d = 1'b1;
        end else overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      osr_q <= '0;
      mode_q <= MODE_INCREMENTAL;
      res_data_q <= '0;
      res_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      osr_q <= osr_d;
      mode_q <= mode_d;
      res_data_q <= res_data_d;
      res_valid_q <= res_valid_d;
      overrun_q <= overrun_d;
    end
  assign flt_clr = state_q == ST_CLEAR;
  assign flt_en = state_q == ST_INTEGRATE;
  assign busy = state_q != ST_IDLE;
  assign res_data = res_data_q;
  assign res_valid = res_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_decimation_sequencer.sv
// tb_decimation_sequencer: directed checks of conversion timing, modes, handshake, overrun and reset.
module tb_decimation_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic mode = 1'b0;
  logic [7:0] osr = 8'd4;
  logic flt_clr, flt_en, res_valid, busy, overrun;
  logic [15:0] flt_data = 16'hA000;
  logic [15:0] res_data;
  logic res_ready = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  decimation_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .mode(mode), .osr(osr),
    .flt_clr(flt_clr), .flt_en(flt_en), .flt_data(flt_data), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .overrun(overrun)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    flt_data = 16'hA000 + 16'(cyc);
  endtask
  task automatic begin_test();
    cyc = 0;
    flt_data = 16'hA000;
  endtask
  task automatic test_reset();
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (flt_clr !== 1'b0 || flt_en !== 1'b0) begin bad++; $display("FAIL reset_flt got=%b%b exp=00", flt_clr, flt_en); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    total++; if (res_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", res_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after got=%b exp=0", busy); end
  endtask
  task automatic test_single();
    begin_test();
    osr = 8'd16; mode = 1'b0; res_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
      if (k == 5) begin osr = 8'd3; mode = 1'b1; end
      total++; if (flt_clr !== (k == 1)) begin bad++; $display("FAIL single_clr k=%0d got=%b", k, flt_clr); end
      total++; if (flt_en !== (k >= 2 && k <= 17)) begin bad++; $display("FAIL single_en k=%0d got=%b", k, flt_en); end
      total++; if (res_valid !== (k == 19)) begin bad++; $display("FAIL single_valid k=%0d got=%b", k, res_valid); end
      total++; if (busy !== (k <= 18)) begin bad++; $display("FAIL single_busy k=%0d got=%b", k, busy); end
      if (k >= 19) begin
        total++; if (res_data !== 16'hA012) begin bad++; $display("FAIL single_data k=%0d got=%h exp=a012", k, res_data); end
      end
    end
    osr = 8'd4; mode = 1'b0;
  endtask
  task automatic test_continuous_incr();
    int clrs = 0;
    begin_test();
    osr = 8'd4; mode = 1'b0; res_ready = 1'b1; continuous = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 18) continuous = 1'b0;
      if (flt_clr) clrs++;
      total++; if (flt_clr !== (k == 1 || k == 7 || k == 13)) begin bad++; $display("FAIL cont_clr k=%0d got=%b", k, flt_clr); end
      total++; if (res_valid !== (k == 7 || k == 13 || k == 19)) begin bad++; $display("FAIL cont_valid k=%0d got=%b", k, res_valid); end
      if (k == 7 || k == 13 || k == 19) begin
        total++; if (res_data !== 16'hA000 + 16'(k - 1)) begin bad++; $display("FAIL cont_data k=%0d got=%h exp=%h", k, res_data, 16'hA000 + 16'(k - 1)); end
      end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL cont_overrun k=%0d got=%b exp=0", k, overrun); end
    end
    total++; if (clrs != 3) begin bad++; $display("FAIL cont_clr_count got=%0d exp=3", clrs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", busy); end
  endtask
  task automatic test_regular();
    begin_test();
    osr = 8'd4; mode = 1'b1; res_ready = 1'b1; continuous = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) mode = 1'b0;
      if (k == 16) continuous = 1'b0;
      total++; if (flt_clr !== (k == 1)) begin bad++; $display("FAIL reg_clr k=%0d got=%b", k, flt_clr); end
      total++; if (flt_en !== (k >= 2 && (k - 1) % 5 != 0)) begin bad++; $display("FAIL reg_en k=%0d got=%b", k, flt_en); end
    end
    tick();
    total++; if (busy !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'hA010) begin
      bad++; $display("FAIL reg_end busy=%b valid=%b data=%h exp=0/1/a010", busy, res_valid, res_data);
    end
    tick();
  endtask
  task automatic test_overrun();
    begin_test();
    osr = 8'd4; mode = 1'b0; res_ready = 1'b0; continuous = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 13) continuous = 1'b0;
      if (k == 20) begin start = 1'b1; res_ready = 1'b1; end
      if (k >= 7 && k <= 20) begin
        total++; if (res_valid !== 1'b1 || res_data !== 16'hA006) begin bad++; $display("FAIL ovr_hold k=%0d valid=%b data=%h exp=1/a006", k, res_valid, res_data); end
      end
      total++; if (overrun !== (k >= 13 && k <= 20)) begin bad++; $display("FAIL ovr_flag k=%0d got=%b", k, overrun); end
    end
    start = 1'b0;
    total++; if (busy !== 1'b1 || flt_clr !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_restart busy=%b clr=%b valid=%b exp=1/1/0", busy, flt_clr, res_valid);
    end
    for (int k = 22; k <= 28; k++) begin
      tick();
      total++; if (res_valid !== (k == 27)) begin bad++; $display("FAIL ovr_new_valid k=%0d got=%b", k, res_valid); end
      if (k == 27) begin
        total++; if (res_data !== 16'hA01A) begin bad++; $display("FAIL ovr_new_data got=%h exp=a01a", res_data); end
      end
    end
  endtask
  task automatic test_min_osr();
    logic [7:0] vals [2];
    vals[0] = 8'd0; vals[1] = 8'd1;
    for (int v = 0; v < 2; v++) begin
      int ens = 0;
      begin_test();
      osr = vals[v]; mode = 1'b0; res_ready = 1'b1; start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        tick();
        start = 1'b0;
        if (flt_en) ens++;
        total++; if (res_valid !== (k == 5)) begin bad++; $display("FAIL min_valid osr=%0d k=%0d got=%b", vals[v], k, res_valid); end
      end
      total++; if (ens != 2) begin bad++; $display("FAIL min_en_count osr=%0d got=%0d exp=2", vals[v], ens); end
      total++; if (res_data !== 16'hA004) begin bad++; $display("FAIL min_data osr=%0d got=%h exp=a004", vals[v], res_data); end
    end
  endtask
  task automatic test_reset_mid();
    begin_test();
    osr = 8'd8; mode = 1'b0; res_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
    end
    total++; if (flt_en !== 1'b1) begin bad++; $display("FAIL mid_pre_en got=%b exp=1", flt_en); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, flt_clr, flt_en, res_valid, overrun} !== 5'b0) begin
      bad++; $display("FAIL mid_abort bcevo=%b exp=00000", {busy, flt_clr, flt_en, res_valid, overrun});
    end
    total++; if (res_data !== 16'h0) begin bad++; $display("FAIL mid_data got=%h exp=0000", res_data); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({busy, flt_clr, flt_en, res_valid} !== 4'b0) begin
        bad++; $display("FAIL mid_after k=%0d bcev=%b exp=0000", k, {busy, flt_clr, flt_en, res_valid});
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_continuous_incr();
    test_regular();
    test_overrun();
    test_min_osr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decimation_sequencer.md
DECIMATION_SEQUENCER -- requirements
Module: decimation_sequencer

Interface
REQ-001 Parameter OUTPUT_BITS, default 16, SHALL set the width of filter result data.
REQ-002 Parameter OSR_BITS, default 8, SHALL set the width of the oversampling-ratio field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request one conversion when high in IDLE.
REQ-006 continuous  input  1  SHALL request back-to-back conversions when high; sampled live.
REQ-007 mode  input  1  SHALL select the filter type: 0 = incremental (clear per conversion), 1 = regular (clear once, free-running).
REQ-008 osr  input  OSR_BITS  SHALL give the modulator samples per conversion.
REQ-009 flt_clr  output  1  SHALL be the filter/modulator integrator clear pulse.
REQ-010 flt_en  output  1  SHALL be the filter sample enable.
REQ-011 flt_data  input  OUTPUT_BITS  SHALL be the filter output, valid in the CAPTURE cycle.
REQ-012 res_data  output  OUTPUT_BITS  SHALL be the latched conversion result.
REQ-013 res_valid / res_ready  output / input  1 each  SHALL form the result handshake; transfer when both are high on a clock edge.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 overrun  output  1  SHALL be a sticky flag for a dropped result.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, INTEGRATE and CAPTURE; flt_clr and flt_en SHALL be Moore outputs decoded from the state.
REQ-017 IDLE SHALL go to CLEAR when start or continuous is high, and SHALL latch osr into osr_q and mode into mode_q on that edge.
REQ-018 osr_q SHALL be forced to 2 when osr < 2.
REQ-019 A start pulse that leaves IDLE SHALL clear overrun; start while busy SHALL be ignored.
REQ-020 CLEAR SHALL last exactly one cycle with flt_clr=1 and flt_en=0, and SHALL reset the sample counter to 0 before moving to INTEGRATE.
REQ-021 INTEGRATE SHALL hold flt_en=1 and increment the counter each cycle, moving to CAPTURE when counter == osr_q-1, for exactly osr_q enabled cycles.
REQ-022 CAPTURE SHALL last one cycle with flt_en=0 and flt_clr=0.
REQ-023 CAPTURE exit: continuous=0 SHALL go to IDLE; with continuous=1, mode_q=0 SHALL go to CLEAR and mode_q=1 SHALL go to INTEGRATE (no clear, counter reset).
REQ-024 Latency: start high in cycle 0 SHALL give flt_clr in cycle 1, flt_en in cycles 2..osr_q+1, CAPTURE in cycle osr_q+2, and res_valid high from cycle osr_q+3.
REQ-025 In CAPTURE, when res_valid=0 or res_ready=1, the block SHALL load res_data from flt_data and set res_valid=1.
REQ-026 In CAPTURE, when res_valid=1 and res_ready=0, the block SHALL keep the old res_data, keep res_valid=1 and set overrun=1.
REQ-027 Outside CAPTURE, res_valid SHALL clear on a transfer and res_data SHALL stay stable while res_valid=1.
REQ-028 Changes to osr or mode during a conversion SHALL take effect only at the next IDLE exit.
REQ-029 The counter SHALL be OSR_BITS wide and SHALL never wrap within a conversion.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and all of the following SHALL be 0: counter, osr_q, mode_q, res_data, res_valid, overrun, busy, flt_clr, flt_en.
REQ-031 Reset asserted mid-conversion SHALL abort it immediately with no result and no flt_clr pulse, and the first clr after release SHALL come only from a new request.

Structure
REQ-032 The state enum, the MIN_OSR constant (2) and the mode encodings SHALL live in package decimation_pkg.
REQ-033 The sample counter with terminal-count compare SHALL be a sub-module named sample_counter.

Verification
REQ-034 osr=16, mode=0, start pulse at cycle 0, res_ready=1 -> flt_clr at cycle 1 only, flt_en cycles 2-17, res_valid at cycle 19 with res_data=flt_data from cycle 18.
REQ-035 osr=4, mode=0, continuous=1 for 3 conversions -> flt_clr every 6 cycles, 3 results, overrun=0.
REQ-036 osr=4, mode=1, continuous=1 -> one flt_clr, then flt_en 4 on / 1 off repeating with no further clr.
REQ-037 osr=4, continuous=1, res_ready=0 -> first result held, overrun=1 at second CAPTURE, res_data unchanged; a later start clears overrun.
REQ-038 osr=0 and osr=1 -> 2 flt_en cycles per conversion; rst_n low in INTEGRATE cycle 3 -> all outputs 0, IDLE, no res_valid.
